// File: rtl/ae18_rstk.sv
// AE18 return-stack controller: owns STKPTR, drives the external asynchronous
// stack RAM, presents TOS combinationally and tracks overflow/underflow faults.
module ae18_rstk #(
  parameter int unsigned ISIZ = 24,
  parameter int unsigned SSIZ = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [ISIZ-1:0] pc_in,
  input  logic            tos_we,
  input  logic [ISIZ-1:0] tos_wdat,
  input  logic            ptr_we,
  input  logic [SSIZ-1:0] ptr_wdat,
  input  logic            flg_clr,
  input  logic            stvren,
  output logic [ISIZ-1:0] tos,
  output logic [SSIZ-1:0] stkptr,
  output logic            stkful,
  output logic            stkunf,
  output logic            stk_rst,
  output logic [ISIZ-1:0] m_wdat,
  output logic [SSIZ-1:0] m_wadr,
  output logic [SSIZ-1:0] m_radr,
  output logic            m_we,
  input  logic [ISIZ-1:0] m_rdat
);

  localparam logic [SSIZ-1:0] PtrMax = '1;
  localparam logic [SSIZ-1:0] PtrOne = {{(SSIZ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PTR_WR,
    OP_PUSH,
    OP_REPLACE,
    OP_POP,
    OP_TOS_WR
  } op_e;

  logic [SSIZ-1:0] stkptr_q, stkptr_d;
  logic            stkful_q, stkful_d;
  logic            stkunf_q, stkunf_d;
  logic            stk_rst_q, stk_rst_d;

  logic            ptr_empty;
  logic            ptr_full;
  logic [SSIZ-1:0] ptr_inc;
  logic [SSIZ-1:0] ptr_dec;
  op_e             op;
  logic            ovf_evt;
  logic            unf_evt;
  logic            we_raw;

  assign ptr_empty = (stkptr_q == '0);
  assign ptr_full  = (stkptr_q == PtrMax);
  assign ptr_inc   = stkptr_q + PtrOne;
  assign ptr_dec   = stkptr_q - PtrOne;

  // Command decode; push+pop on an empty stack degenerates to a plain push.
  always_comb begin
    op = OP_IDLE;
    if (ptr_we) begin
      op = OP_PTR_WR;
    end else if (push && pop && !ptr_empty) begin
      op = OP_REPLACE;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop) begin
      op = OP_POP;
    end else if (tos_we) begin
      op = OP_TOS_WR;
    end
  end

  always_comb begin
    stkptr_d = stkptr_q;
    we_raw   = 1'b0;
    m_wadr   = ptr_inc;
    m_wdat   = pc_in;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    unique case (op)
      OP_PTR_WR: begin
        stkptr_d = ptr_wdat;
      end
      OP_PUSH: begin
        if (ptr_full) begin
          ovf_evt = 1'b1;
        end else begin
          we_raw   = 1'b1;
          stkptr_d = ptr_inc;
        end
      end
      OP_REPLACE: begin
        we_raw = 1'b1;
        m_wadr = stkptr_q;
      end
      OP_POP: begin
        if (ptr_empty) begin
          unf_evt = 1'b1;
        end else begin
          stkptr_d = ptr_dec;
        end
      end
      OP_TOS_WR: begin
        if (!ptr_empty) begin
          we_raw = 1'b1;
          m_wadr = stkptr_q;
          m_wdat = tos_wdat;
        end
      end
      default: begin
      end
    endcase
  end

  // A fault raised this cycle takes precedence over a simultaneous flag clear.
  always_comb begin
    stkful_d  = stkful_q;
    stkunf_d  = stkunf_q;
    if (flg_clr) begin
      stkful_d = 1'b0;
      stkunf_d = 1'b0;
    end
    if (ovf_evt) stkful_d = 1'b1;
    if (unf_evt) stkunf_d = 1'b1;
    stk_rst_d = (ovf_evt || unf_evt) && stvren;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stkptr_q  <= '0;
      stkful_q  <= 1'b0;
      stkunf_q  <= 1'b0;
      stk_rst_q <= 1'b0;
    end else begin
      stkptr_q  <= stkptr_d;
      stkful_q  <= stkful_d;
      stkunf_q  <= stkunf_d;
      stk_rst_q <= stk_rst_d;
    end
  end

  assign m_we    = we_raw && rst_n;
  assign m_radr  = stkptr_q;
  assign tos     = ptr_empty ? '0 : m_rdat;
  assign stkptr  = stkptr_q;
  assign stkful  = stkful_q;
  assign stkunf  = stkunf_q;
  assign stk_rst = stk_rst_q;

endmodule

// File: tb/tb_ae18_rstk.sv
// Directed bench for ae18_rstk with a behavioural 32x24 asynchronous stack RAM.
module tb_ae18_rstk;

  logic        clk = 1'b0;
  logic        rstN;
  logic        push, pop, tosWe, ptrWe, flgClr, stvren;
  logic [23:0] pcIn, tosWdat;
  logic [4:0]  ptrWdat;
  logic [23:0] tos, mWdat, mRdat;
  logic [4:0]  stkptr, mWadr, mRadr;
  logic        stkful, stkunf, stkRst, mWe;

  logic [23:0] ram [32];
  int          checks = 0;
  int          failures = 0;

  ae18_rstk #(.ISIZ(24), .SSIZ(5)) dut (
    .clk(clk), .rst_n(rstN), .push(push), .pop(pop), .pc_in(pcIn),
    .tos_we(tosWe), .tos_wdat(tosWdat), .ptr_we(ptrWe), .ptr_wdat(ptrWdat),
    .flg_clr(flgClr), .stvren(stvren), .tos(tos), .stkptr(stkptr),
    .stkful(stkful), .stkunf(stkunf), .stk_rst(stkRst), .m_wdat(mWdat),
    .m_wadr(mWadr), .m_radr(mRadr), .m_we(mWe), .m_rdat(mRdat)
  );

  always #5 clk = ~clk;

  // Stack RAM model: write on the rising edge, read asynchronously.
  always @(posedge clk) if (mWe) ram[mWadr] <= mWdat;
  assign mRdat = ram[mRadr];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic q, input logic [23:0] pc);
    push = p;
    pop  = q;
    pcIn = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 24'h0;
    rstN = 1'b0; ptrWe = 1'b0; ptrWdat = '0; tosWe = 1'b0; tosWdat = '0;
    flgClr = 1'b0; stvren = 1'b0;
    applyStimulus(1'b1, 1'b0, 24'h0000AA);
    #1;
    checkOutput("weInReset", mWe, 1'b0);
    tick();
    tick();
    checkOutput("rstPtr", stkptr, 5'd0);
    checkOutput("rstFul", stkful, 1'b0);
    checkOutput("rstUnf", stkunf, 1'b0);
    checkOutput("rstStkRst", stkRst, 1'b0);
    checkOutput("rstTos", tos, 24'h0);

    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 24'h000055);
    #1;
    checkOutput("idleWe", mWe, 1'b0);
    checkOutput("idleWadr", mWadr, 5'd1);
    checkOutput("idleWdat", mWdat, 24'h000055);

    applyStimulus(1'b1, 1'b0, 24'h000100);
    #1;
    checkOutput("push1We", mWe, 1'b1);
    checkOutput("push1Wadr", mWadr, 5'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 24'h000200);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("t1Ptr", stkptr, 5'd2);
    checkOutput("t1Tos", tos, 24'h000200);
    applyStimulus(1'b0, 1'b1, 24'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("t1PopPtr", stkptr, 5'd1);
    checkOutput("t1PopTos", tos, 24'h000100);
    applyStimulus(1'b0, 1'b1, 24'h0);
    tick();

    applyStimulus(1'b0, 1'b1, 24'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("unfPtr", stkptr, 5'd0);
    checkOutput("unfFlag", stkunf, 1'b1);
    checkOutput("unfTos", tos, 24'h0);
    checkOutput("unfNoRst", stkRst, 1'b0);

    flgClr = 1'b1;
    applyStimulus(1'b0, 1'b1, 24'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("unfBeatsClr", stkunf, 1'b1);
    tick();
    flgClr = 1'b0;
    #1;
    checkOutput("clrUnf", stkunf, 1'b0);

    stvren = 1'b1;
    applyStimulus(1'b0, 1'b1, 24'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("unfRstPulse", stkRst, 1'b1);
    flgClr = 1'b1;
    tick();
    flgClr = 1'b0;
    #1;
    checkOutput("unfRstDrop", stkRst, 1'b0);

    for (int v = 1; v <= 31; v++) begin
      applyStimulus(1'b1, 1'b0, 24'(v));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("fillPtr", stkptr, 5'd31);
    checkOutput("fillFul", stkful, 1'b0);
    checkOutput("fillTos", tos, 24'd31);
    applyStimulus(1'b1, 1'b0, 24'd32);
    #1;
    checkOutput("ovfNoWe", mWe, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("ovfPtr", stkptr, 5'd31);
    checkOutput("ovfFul", stkful, 1'b1);
    checkOutput("ovfRam31", ram[31], 24'd31);
    checkOutput("ovfRstPulse", stkRst, 1'b1);
    tick();
    checkOutput("ovfRstDrop", stkRst, 1'b0);
    checkOutput("ovfFulSticky", stkful, 1'b1);

    stvren = 1'b0;
    applyStimulus(1'b1, 1'b0, 24'd33);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("ovfNoRst", stkRst, 1'b0);

    ptrWe = 1'b1; ptrWdat = 5'd3;
    tick();
    ptrWe = 1'b0;
    #1;
    checkOutput("ptrWrPtr", stkptr, 5'd3);
    checkOutput("ptrWrFulKept", stkful, 1'b1);
    applyStimulus(1'b1, 1'b1, 24'hABCDEF);
    #1;
    checkOutput("replWadr", mWadr, 5'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("replPtr", stkptr, 5'd3);
    checkOutput("replTos", tos, 24'hABCDEF);
    checkOutput("replRam2", ram[2], 24'd2);

    ptrWe = 1'b1; ptrWdat = 5'd5;
    applyStimulus(1'b1, 1'b0, 24'h000777);
    #1;
    checkOutput("ptrOverPushWe", mWe, 1'b0);
    tick();
    ptrWe = 1'b0;
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("ptrOverPushPtr", stkptr, 5'd5);
    checkOutput("ptrOverPushRam6", ram[6], 24'd6);
    tosWe = 1'b1; tosWdat = 24'h123456;
    tick();
    tosWe = 1'b0;
    #1;
    checkOutput("tosWrRam5", ram[5], 24'h123456);
    checkOutput("tosWrTos", tos, 24'h123456);
    checkOutput("tosWrPtr", stkptr, 5'd5);

    ptrWe = 1'b1; ptrWdat = 5'd0; flgClr = 1'b1;
    tick();
    ptrWe = 1'b0; flgClr = 1'b0;
    #1;
    checkOutput("clrFul", stkful, 1'b0);
    tosWe = 1'b1; tosWdat = 24'h654321;
    #1;
    checkOutput("tosWrEmptyWe", mWe, 1'b0);
    tosWe = 1'b0;
    applyStimulus(1'b1, 1'b1, 24'h0000C3);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0);
    #1;
    checkOutput("replEmptyPtr", stkptr, 5'd1);
    checkOutput("replEmptyTos", tos, 24'h0000C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
